led_sched: RTL and testbench
============================

# led_sched

LED ownership scheduler placed between the Nios II LED PIO export and the eight board LED pins. It shares the LEDs between two requesters: the CPU, which writes through the PIO, and a built-in hardware pattern engine. A CPU write takes ownership for a programmable hold time, after which the pattern engine resumes from the value it held. A PWM gate applies global brightness to whichever source currently owns the LEDs.

## Interface
- TICK_DIV, 5_000_000, clk cycles per pattern tick (100 ms at 50 MHz); must be ≥2
- HOLD_TICKS, 20, ticks the CPU keeps ownership after its last write; 0 = hold until disabled
- PWM_BITS, 4, width of the brightness duty value and the PWM counter

- clk  in  1  system clock, the single clock for the whole block
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  0 forces the LEDs off and the FSM to OFF
- pio_led  in  8  CPU LED value from the PIO export
- pio_wr  in  1  one-cycle strobe: pio_led is valid this cycle
- mode  in  2  pattern select: 0 chase, 1 binary count, 2 blink, 3 dark
- duty  in  PWM_BITS  brightness; 0 = off, all-ones = full on
- led_output  out  8  registered LED drive, 1 = lit
- cpu_owns  out  1  registered; 1 while the FSM is in CPU
- tick  out  1  one-cycle pulse at each pattern tick

## Operation
- **Tick counter**
  - Counts 0..TICK_DIV-1 and wraps.
  - `tick` = 1 when the count equals TICK_DIV-1.
  - Held at 0 while enable=0.
- **PWM counter**
  - PWM_BITS wide, free-running, increments every cycle while enable=1, wraps.
  - gate = (duty == all-ones) | (pwm_cnt < duty).
- **Pattern register `pat`**
  - Seed per mode: 0→8'h01, 1→8'h00, 2→8'hFF, 3→8'h00.
  - Advances on `tick` only in state PATTERN:
    - mode 0: rotate left, 8'h80→8'h01.
    - mode 1: +1 mod 256.
    - mode 2: bitwise invert.
    - mode 3: stays 8'h00.
  - A change of `mode` (compared against a registered copy) reloads the seed on the next cycle, in any state. The reload takes priority over advance.
- **FSM states: OFF, PATTERN, CPU.** enable=0 in any state → OFF, with highest priority.
  - OFF: pio_wr is ignored. enable=1 → PATTERN and `pat` is loaded with the seed.
  - PATTERN: pio_wr → CPU; latch `cpu_val`=pio_led; hold_cnt=HOLD_TICKS.
  - CPU:
    - pio_wr relatches `cpu_val` and reloads hold_cnt.
    - When HOLD_TICKS≠0, a tick decrements hold_cnt. A tick with hold_cnt==1 → PATTERN, and `pat` resumes unchanged (no reseed).
    - pio_wr in the same cycle as the expiring tick: the write wins and the FSM stays in CPU.
- **Source select:** CPU→cpu_val, PATTERN→pat, OFF→8'h00.
- **Output:** led_output <= source & {8{gate}}.
- hold_cnt width is clog2(HOLD_TICKS+1). All arithmetic is unsigned and wraps.

## Timing
- **Reset values:** led_output=8'h00, cpu_owns=0, tick=0; state OFF; tick, PWM and hold counters 0; pat=8'h01; cpu_val=8'h00.
- rst_n low clears everything immediately, without waiting for clk, including in the middle of a hold. Deassertion is synchronous to clk.
- **Latency:**
  - pio_wr at edge N → state CPU after N; led_output and cpu_owns reflect it after N+1.
  - enable 0→1 at N → PATTERN after N; first pattern value at led_output after N+1.
  - enable 1→0 → led_output=8'h00 two edges later.
- `tick` is registered. `pat` updates on the edge that samples `tick`=1, and led_output shows the new value one edge later.
- CPU hold lasts exactly HOLD_TICKS tick pulses after the write, with partial tick period counted as the first.

## Test plan
Bench uses TICK_DIV=4, HOLD_TICKS=2, PWM_BITS=4.
- **Chase:** reset release, enable=1, mode=0, duty=15 → led_output 01 two cycles later, then 02, 04…80, 01, advancing every 4 cycles.
- **CPU override:** pio_wr with pio_led=A5 during chase at pat=04 → led_output=A5 and cpu_owns=1 two cycles later. After the second tick → cpu_owns=0 and led_output=04, then 08.
- **Write at expiry:** pio_wr with 3C on the cycle of the expiring tick → stays CPU, led_output=3C, and two more ticks pass before release.
- **PWM:** mode=2 with pat=FF, duty=4 → led_output=FF for exactly 4 of every 16 cycles, otherwise 00. duty=0 → constant 00.
- **Mode 1 wrap:** count from seed 00 through FF → next tick gives 00. A mode change mid-count → reseed on the next cycle.
- **Disable / async reset:**
  - enable=0 in the middle of a CPU hold → led_output=00 and cpu_owns=0. Re-enable → PATTERN restarts from the seed.
  - rst_n pulse mid-cycle → outputs 0 before the next clk edge.

Source files
------------

// File: rtl/led_sched.sv
// led_sched: shares the eight board LEDs between the CPU (PIO writes) and a
// built-in pattern engine. A CPU write takes ownership for HOLD_TICKS pattern
// ticks; afterwards the pattern engine resumes from the value it held. A PWM
// gate applies global brightness to whichever source currently owns the LEDs.
module led_sched #(
  parameter int TICK_DIV   = 5_000_000,
  parameter int HOLD_TICKS = 20,
  parameter int PWM_BITS   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [7:0]          pio_led,
  input  logic                pio_wr,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] duty,
  output logic [7:0]          led_output,
  output logic                cpu_owns,
  output logic                tick
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  localparam logic [TW-1:0]       TICK_LAST  = TW'(TICK_DIV - 1);
  // tick is registered, so it is set one count early to be high exactly
  // while the counter sits at its last value.
  localparam logic [TW-1:0]       TICK_PRE   = TW'(TICK_DIV - 2);
  localparam logic [TW-1:0]       TICK_ZERO  = {TW{1'b0}};
  localparam logic [TW-1:0]       TICK_ONE   = TW'(1);
  localparam logic [HW-1:0]       HOLD_LOAD  = HW'(HOLD_TICKS);
  localparam logic [HW-1:0]       HOLD_ONE   = HW'(1);
  localparam logic [HW-1:0]       HOLD_ZERO  = {HW{1'b0}};
  localparam logic [PWM_BITS-1:0] PWM_FULL   = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] PWM_ONE    = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] PWM_ZERO   = {PWM_BITS{1'b0}};
  localparam bit                  HOLD_TIMED = (HOLD_TICKS != 0);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_PATTERN = 2'd1,
    ST_CPU     = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [TW-1:0]         tick_cnt_r;
  logic                  tick_r;
  logic [PWM_BITS-1:0]   pwm_cnt_r;
  logic                  gate_s;
  logic [7:0]            pat_r;
  logic [1:0]            mode_r;
  logic                  mode_chg_s;
  logic [7:0]            cpu_val_r;
  logic [HW-1:0]         hold_cnt_r;
  logic                  take_s;
  logic                  hold_dec_s;
  logic [7:0]            source_s;
  logic [7:0]            led_r;
  logic                  cpu_owns_r;

  // Starting value of the pattern for each mode.
  function automatic logic [7:0] seed_of(input logic [1:0] m);
    logic [7:0] s;
    case (m)
      2'd0:    s = 8'h01;
      2'd1:    s = 8'h00;
      2'd2:    s = 8'hFF;
      2'd3:    s = 8'h00;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Next pattern value on a tick for each mode.
  function automatic logic [7:0] advance(input logic [7:0] p, input logic [1:0] m);
    logic [7:0] n;
    case (m)
      2'd0:    n = {p[6:0], p[7]};
      2'd1:    n = p + 8'd1;
      2'd2:    n = ~p;
      2'd3:    n = 8'h00;
      default: n = 8'h00;
    endcase
    return n;
  endfunction

  assign mode_chg_s = (mode != mode_r);
  assign hold_dec_s = HOLD_TIMED && enable && tick_r && (state_r == ST_CPU);
  assign gate_s     = (duty == PWM_FULL) || (pwm_cnt_r < duty);

  // Pattern tick divider; parked at zero while the block is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= TICK_ZERO;
      tick_r     <= 1'b0;
    end else if (!enable) begin
      tick_cnt_r <= TICK_ZERO;
      tick_r     <= 1'b0;
    end else begin
      tick_cnt_r <= (tick_cnt_r == TICK_LAST) ? TICK_ZERO : tick_cnt_r + TICK_ONE;
      tick_r     <= (tick_cnt_r == TICK_PRE);
    end
  end

  // Free-running PWM phase counter, advancing only while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_r <= PWM_ZERO;
    end else if (enable) begin
      pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
    end else begin
      pwm_cnt_r <= pwm_cnt_r;
    end
  end

  // Ownership state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_OFF;
    end else begin
      state_r <= state_s;
    end
  end

  // Next ownership state; a write in the expiring-tick cycle keeps the CPU.
  always_comb begin
    state_s = state_r;
    take_s  = 1'b0;
    if (!enable) begin
      state_s = ST_OFF;
    end else begin
      case (state_r)
        ST_OFF: begin
          state_s = ST_PATTERN;
        end
        ST_PATTERN: begin
          if (pio_wr) begin
            state_s = ST_CPU;
            take_s  = 1'b1;
          end else begin
            state_s = ST_PATTERN;
          end
        end
        ST_CPU: begin
          if (pio_wr) begin
            state_s = ST_CPU;
            take_s  = 1'b1;
          end else if (hold_dec_s && (hold_cnt_r == HOLD_ONE)) begin
            state_s = ST_PATTERN;
          end else begin
            state_s = ST_CPU;
          end
        end
        default: begin
          state_s = ST_OFF;
        end
      endcase
    end
  end

  // CPU hold countdown and latched CPU value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_r <= HOLD_ZERO;
      cpu_val_r  <= 8'h00;
    end else if (!enable) begin
      hold_cnt_r <= HOLD_ZERO;
      cpu_val_r  <= cpu_val_r;
    end else if (take_s) begin
      hold_cnt_r <= HOLD_LOAD;
      cpu_val_r  <= pio_led;
    end else if (hold_dec_s) begin
      hold_cnt_r <= hold_cnt_r - HOLD_ONE;
      cpu_val_r  <= cpu_val_r;
    end else begin
      hold_cnt_r <= hold_cnt_r;
      cpu_val_r  <= cpu_val_r;
    end
  end

  // Pattern engine: reseed on mode change or start-up, advance on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_r  <= 8'h01;
      mode_r <= 2'd0;
    end else begin
      mode_r <= mode;
      if (mode_chg_s || (enable && (state_r == ST_OFF))) begin
        pat_r <= seed_of(mode);
      end else if (enable && tick_r && (state_r == ST_PATTERN)) begin
        pat_r <= advance(pat_r, mode_r);
      end else begin
        pat_r <= pat_r;
      end
    end
  end

  // Source select for the current owner.
  always_comb begin
    source_s = 8'h00;
    case (state_r)
      ST_CPU:     source_s = cpu_val_r;
      ST_PATTERN: source_s = pat_r;
      default:    source_s = 8'h00;
    endcase
  end

  // Registered, brightness-gated LED drive and ownership flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r      <= 8'h00;
      cpu_owns_r <= 1'b0;
    end else begin
      led_r      <= source_s & {8{gate_s}};
      cpu_owns_r <= (state_r == ST_CPU);
    end
  end

  assign led_output = led_r;
  assign cpu_owns   = cpu_owns_r;
  assign tick       = tick_r;

endmodule

// File: tb/tb_led_sched.sv
// Directed testbench for led_sched with TICK_DIV=4, HOLD_TICKS=2, PWM_BITS=4.
// Edge numbers in comments count clk edges from the one that first samples
// enable=1 (E0); outputs are sampled 1 ns after each rising edge.
module tb_led_sched;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] pio_led;
  logic       pio_wr;
  logic [1:0] mode;
  logic [3:0] duty;
  logic [7:0] led_output;
  logic       cpu_owns;
  logic       tick;

  int         n_tests;
  int         n_fail;
  logic [7:0] exp_v;
  logic [7:0] on_cnt;

  led_sched #(.TICK_DIV(4), .HOLD_TICKS(2), .PWM_BITS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pio_led    (pio_led),
    .pio_wr     (pio_wr),
    .mode       (mode),
    .duty       (duty),
    .led_output (led_output),
    .cpu_owns   (cpu_owns),
    .tick       (tick)
  );

  // 100 MHz-style bench clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    enable  = 1'b0;
    pio_led = 8'h00;
    pio_wr  = 1'b0;
    mode    = 2'd0;
    duty    = 4'd15;

    // Reset state
    step(2);
    chk("reset_led", led_output, 8'h00);
    chk1("reset_cpu_owns", cpu_owns, 1'b0);
    chk1("reset_tick", tick, 1'b0);
    rst_n = 1'b1;
    step(1);
    chk("idle_disabled_led", led_output, 8'h00);

    // Chase
    enable = 1'b1;
    step(1);                                   // E0
    chk("chase_e0_led", led_output, 8'h00);
    step(1);                                   // E1
    chk("chase_first", led_output, 8'h01);
    step(1);                                   // E2
    chk1("chase_tick_hi", tick, 1'b1);
    step(1);                                   // E3
    chk1("chase_tick_lo", tick, 1'b0);
    chk("chase_hold01", led_output, 8'h01);
    step(1);                                   // E4
    chk("chase_02", led_output, 8'h02);
    exp_v = 8'h02;
    for (int k = 2; k <= 8; k++) begin
      exp_v = {exp_v[6:0], exp_v[7]};
      step(4);                                 // E8 .. E32
      chk("chase_step", led_output, exp_v);
    end
    step(8);                                   // E40
    chk("chase_at_04", led_output, 8'h04);

    // CPU override
    pio_led = 8'hA5;
    pio_wr  = 1'b1;
    step(1);                                   // E41
    pio_wr  = 1'b0;
    chk1("cpu_owns_lat", cpu_owns, 1'b0);
    chk("cpu_led_lat", led_output, 8'h04);
    step(1);                                   // E42
    chk("cpu_led", led_output, 8'hA5);
    chk1("cpu_owns", cpu_owns, 1'b1);
    step(4);                                   // E46
    chk1("cpu_hold_one_tick", cpu_owns, 1'b1);
    step(1);                                   // E47
    chk("cpu_last_led", led_output, 8'hA5);
    step(1);                                   // E48
    chk1("cpu_release_owns", cpu_owns, 1'b0);
    chk("cpu_release_resume", led_output, 8'h04);
    step(4);                                   // E52
    chk("resume_advance", led_output, 8'h08);

    // Write at expiry
    pio_led = 8'h5A;
    pio_wr  = 1'b1;
    step(1);                                   // E53
    pio_wr  = 1'b0;
    step(1);                                   // E54
    chk("exp_first_led", led_output, 8'h5A);
    step(4);                                   // E58
    chk1("exp_tick_before", tick, 1'b1);
    pio_led = 8'h3C;
    pio_wr  = 1'b1;
    step(1);                                   // E59: expiring tick + write
    pio_wr  = 1'b0;
    step(1);                                   // E60
    chk("exp_write_wins_led", led_output, 8'h3C);
    chk1("exp_write_wins_owns", cpu_owns, 1'b1);
    step(4);                                   // E64
    chk1("exp_hold_after_tick1", cpu_owns, 1'b1);
    step(3);                                   // E67
    chk1("exp_hold_last", cpu_owns, 1'b1);
    chk("exp_hold_last_led", led_output, 8'h3C);
    step(1);                                   // E68
    chk1("exp_release", cpu_owns, 1'b0);
    chk("exp_release_led", led_output, 8'h08);

    // PWM on a steady all-ones source (CPU rewritten every cycle)
    pio_led = 8'hFF;
    pio_wr  = 1'b1;
    duty    = 4'd4;
    step(2);
    on_cnt = 8'd0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (led_output === 8'hFF) on_cnt = on_cnt + 8'd1;
      else chk("pwm_off_level", led_output, 8'h00);
    end
    chk("pwm_duty4_count", on_cnt, 8'd4);
    duty = 4'd0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      chk("pwm_duty0", led_output, 8'h00);
    end
    pio_wr = 1'b0;
    duty   = 4'd15;
    enable = 1'b0;
    mode   = 2'd1;
    step(2);
    chk("pwm_disable_led", led_output, 8'h00);
    chk1("pwm_disable_owns", cpu_owns, 1'b0);

    // Mode 1 binary count with wrap
    enable = 1'b1;
    step(1);                                   // E0'
    chk("cnt_seed", led_output, 8'h00);
    step(4);                                   // E4'
    chk("cnt_1", led_output, 8'h01);
    for (int k = 2; k <= 256; k++) begin
      exp_v = k[7:0];
      step(4);                                 // E8' .. E1024'
      chk("cnt_step", led_output, exp_v);
    end
    step(12);                                  // E1036'
    chk("cnt_after_wrap", led_output, 8'h03);
    mode = 2'd0;
    step(2);                                   // E1038'
    chk("mode_reseed", led_output, 8'h01);
    step(2);                                   // E1040'
    chk("mode_reseed_adv", led_output, 8'h02);
    step(2);                                   // E1042'
    chk1("mode_tick_hi", tick, 1'b1);
    mode = 2'd2;
    step(2);                                   // E1044'
    chk("mode_reload_beats_adv", led_output, 8'hFF);
    step(4);                                   // E1048'
    chk("blink_invert", led_output, 8'h00);

    // Disable in the middle of a CPU hold
    pio_led = 8'hC3;
    pio_wr  = 1'b1;
    step(1);
    pio_wr  = 1'b0;
    step(1);
    chk("dis_cpu_led", led_output, 8'hC3);
    chk1("dis_cpu_owns", cpu_owns, 1'b1);
    enable = 1'b0;
    step(2);
    chk("dis_led", led_output, 8'h00);
    chk1("dis_owns", cpu_owns, 1'b0);
    pio_led = 8'h77;
    pio_wr  = 1'b1;
    step(1);
    pio_wr  = 1'b0;
    step(2);
    chk("off_ignores_wr_led", led_output, 8'h00);
    chk1("off_ignores_wr_owns", cpu_owns, 1'b0);
    chk1("off_tick_low", tick, 1'b0);
    enable = 1'b1;
    step(2);                                   // E1''
    chk("reenable_seed", led_output, 8'hFF);
    chk1("reenable_owns", cpu_owns, 1'b0);
    step(1);                                   // E2''
    chk1("reenable_tick_phase", tick, 1'b1);

    // Asynchronous reset mid-cycle during a CPU hold
    pio_led = 8'hAA;
    pio_wr  = 1'b1;
    step(1);
    pio_wr  = 1'b0;
    step(1);
    chk("rst_pre_led", led_output, 8'hAA);
    chk1("rst_pre_owns", cpu_owns, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_led", led_output, 8'h00);
    chk1("async_rst_owns", cpu_owns, 1'b0);
    chk1("async_rst_tick", tick, 1'b0);
    step(1);
    rst_n = 1'b1;
    step(2);
    chk("post_rst_seed", led_output, 8'hFF);
    chk1("post_rst_owns", cpu_owns, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
